// File: rtl/cache_types_pkg.sv
// Shared cache types and write-buffer FSM encodings used by l2_write_buffer
// and its line store.
package cache_types_pkg;

  typedef logic [127:0] line_t;
  typedef logic [11:0]  tag_t;

  localparam int WB_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    UP_IDLE,
    UP_WAIT,
    UP_RESP
  } up_state_e;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_READ,
    MEM_WRITE
  } mem_state_e;

  function automatic logic [15:0] line_addr(input tag_t tag);
    return {tag, 4'h0};
  endfunction

endpackage

// File: rtl/l2_wb_store.sv
// Circular line store for the L2 write buffer: enqueue at tail, dequeue at
// head, in-place overwrite, and a parallel youngest-first tag match.
module l2_wb_store
  import cache_types_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq_en,
  input  tag_t             enq_tag,
  input  line_t            enq_data,
  input  logic             deq_en,
  input  logic             ovr_en,
  input  logic [PTR_W-1:0] ovr_idx,
  input  line_t            ovr_data,
  input  tag_t             match_tag,
  input  logic             excl_head,
  output logic             rd_hit,
  output line_t            rd_data,
  output logic             wr_hit,
  output logic [PTR_W-1:0] wr_idx,
  output tag_t             head_tag,
  output line_t            head_data,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  tag_t             tag_q  [DEPTH];
  line_t            data_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_idx;
  logic [PTR_W-1:0] slot;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq_en) tail_d = tail_q + 1'b1;
    if (deq_en) head_d = head_q + 1'b1;
    case ({enq_en, deq_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops see pre-edge values.
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the line storage has no reset; count_q alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (enq_en) begin
      tag_q[tail_q]  <= enq_tag;
      data_q[tail_q] <= enq_data;
    end
    if (ovr_en) data_q[ovr_idx] <= ovr_data;
  end

  // Walk oldest to youngest so the last hit seen is the youngest match.
  always_comb begin
    rd_hit = 1'b0;
    rd_idx = '0;
    wr_hit = 1'b0;
    wr_idx = '0;
    slot   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (tag_q[slot] == match_tag)) begin
        rd_hit = 1'b1;
        rd_idx = slot;
        if (!(excl_head && (i == 0))) begin
          wr_hit = 1'b1;
          wr_idx = slot;
        end
      end
    end
  end

  assign rd_data   = data_q[rd_idx];
  assign head_tag  = tag_q[head_q];
  assign head_data = data_q[head_q];
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/l2_write_buffer.sv
// L2 write-back buffer: upstream and memory FSMs around l2_wb_store.
// Build option: define L2_WB_COALESCE_EN to merge writes into a matching buffered line.
module l2_write_buffer
  import cache_types_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          l2_read,
  input  logic          l2_write,
  input  logic [15:0]   l2_addr,
  input  logic [127:0]  l2_wdata,
  output logic [127:0]  l2_rdata,
  output logic          l2_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [15:0]   pmem_address,
  output logic [127:0]  pmem_wdata,
  input  logic [127:0]  pmem_rdata,
  input  logic          pmem_resp,
  output logic          wb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  up_state_e        up_state_q, up_state_d;
  mem_state_e       mem_state_q, mem_state_d;
  line_t            l2_rdata_q, l2_rdata_d;
  tag_t             miss_tag_q, miss_tag_d;

  tag_t             req_tag;
  logic             enq_en, deq_en, ovr_en;
  logic             rd_hit, wr_hit, coal_hit, full, read_req;
  line_t            rd_data, head_data;
  tag_t             head_tag;
  logic [PTR_W-1:0] wr_idx;
  logic [CNT_W-1:0] count;
  logic             unused_addr_lsbs;

  assign req_tag          = l2_addr[15:4];
  assign unused_addr_lsbs = ^l2_addr[3:0];

  l2_wb_store #(.DEPTH(DEPTH)) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq_en    (enq_en),
    .enq_tag   (req_tag),
    .enq_data  (l2_wdata),
    .deq_en    (deq_en),
    .ovr_en    (ovr_en),
    .ovr_idx   (wr_idx),
    .ovr_data  (l2_wdata),
    .match_tag (req_tag),
    .excl_head (mem_state_q == MEM_WRITE),
    .rd_hit    (rd_hit),
    .rd_data   (rd_data),
    .wr_hit    (wr_hit),
    .wr_idx    (wr_idx),
    .head_tag  (head_tag),
    .head_data (head_data),
    .count     (count),
    .full      (full)
  );

`ifdef L2_WB_COALESCE_EN
  assign coal_hit = wr_hit;
`else
  logic unused_wr_hit;
  assign unused_wr_hit = wr_hit;
  assign coal_hit      = 1'b0;
`endif

  // A read needs memory if it is already waiting or is a fresh miss this cycle.
  assign read_req = (up_state_q == UP_WAIT) ||
                    ((up_state_q == UP_IDLE) && l2_read && !l2_write && !rd_hit);

  always_comb begin
    up_state_d = up_state_q;
    l2_rdata_d = l2_rdata_q;
    miss_tag_d = miss_tag_q;
    enq_en     = 1'b0;
    ovr_en     = 1'b0;
    unique case (up_state_q)
      UP_IDLE: begin
        if (l2_write) begin
          if (coal_hit) begin
            ovr_en     = 1'b1;
            up_state_d = UP_RESP;
          end else if (!full) begin
            enq_en     = 1'b1;
            up_state_d = UP_RESP;
          end
        end else if (l2_read) begin
          if (rd_hit) begin
            l2_rdata_d = rd_data;
            up_state_d = UP_RESP;
          end else begin
            miss_tag_d = req_tag;
            up_state_d = UP_WAIT;
          end
        end
      end
      UP_WAIT: begin
        if ((mem_state_q == MEM_READ) && pmem_resp) begin
          l2_rdata_d = pmem_rdata;
          up_state_d = UP_RESP;
        end
      end
      UP_RESP: up_state_d = UP_IDLE;
      default: up_state_d = UP_IDLE;
    endcase
  end

  // Reads win over drains; a finishing drain hands off straight to a waiting read.
  always_comb begin
    mem_state_d = mem_state_q;
    deq_en      = 1'b0;
    unique case (mem_state_q)
      MEM_IDLE: begin
        if (read_req)           mem_state_d = MEM_READ;
        else if (count != '0)   mem_state_d = MEM_WRITE;
      end
      MEM_READ: begin
        if (pmem_resp) mem_state_d = MEM_IDLE;
      end
      MEM_WRITE: begin
        if (pmem_resp) begin
          deq_en      = 1'b1;
          mem_state_d = read_req ? MEM_READ : MEM_IDLE;
        end
      end
      default: mem_state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_state_q  <= UP_IDLE;
      mem_state_q <= MEM_IDLE;
      l2_rdata_q  <= '0;
      miss_tag_q  <= '0;
    end else begin
      up_state_q  <= up_state_d;
      mem_state_q <= mem_state_d;
      l2_rdata_q  <= l2_rdata_d;
      miss_tag_q  <= miss_tag_d;
    end
  end

  always_comb begin
    pmem_address = '0;
    if (mem_state_q == MEM_READ)       pmem_address = line_addr(miss_tag_q);
    else if (mem_state_q == MEM_WRITE) pmem_address = line_addr(head_tag);
  end

  assign pmem_read  = (mem_state_q == MEM_READ);
  assign pmem_write = (mem_state_q == MEM_WRITE);
  assign pmem_wdata = pmem_write ? head_data : '0;
  assign l2_resp    = (up_state_q == UP_RESP);
  assign l2_rdata   = l2_rdata_q;
  assign wb_empty   = (count == '0);

endmodule

// File: tb/tb_l2_write_buffer.sv
// Scoreboard bench for l2_write_buffer: directed requests push expectations,
// monitors pop them on l2_resp and on pmem_resp.
module tb_l2_write_buffer;
  import cache_types_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         l2_read, l2_write;
  logic [15:0]  l2_addr;
  line_t        l2_wdata, l2_rdata;
  logic         l2_resp;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  line_t        pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic         wb_empty;

  l2_write_buffer #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .l2_read      (l2_read),
    .l2_write     (l2_write),
    .l2_addr      (l2_addr),
    .l2_wdata     (l2_wdata),
    .l2_rdata     (l2_rdata),
    .l2_resp      (l2_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .wb_empty     (wb_empty)
  );

  localparam line_t LINE_A = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam line_t LINE_B = 128'hb0b0_b1b1_b2b2_b3b3_b4b4_b5b5_b6b6_b7b7;
  localparam line_t LINE_C = 128'hc0c1_c2c3_c4c5_c6c7_c8c9_cacb_cccd_cecf;
  localparam line_t LINE_D = 128'hd00d_d11d_d22d_d33d_d44d_d55d_d66d_d77d;
  localparam line_t LINE_E = 128'he1e2_e3e4_e5e6_e7e8_e9ea_ebec_edee_eff0;
  localparam line_t LINE_F = 128'hf0f0_0f0f_f0f0_0f0f_f0f0_0f0f_f0f0_0f0f;

  typedef struct { bit is_read; line_t data; } l2_exp_t;
  typedef struct { logic [15:0] addr; line_t data; } mw_exp_t;

  l2_exp_t     exp_l2[$];
  mw_exp_t     exp_mw[$];
  logic [15:0] exp_mr[$];

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  bit mem_stall = 1'b0;
  int mem_lat = 2;
  int wait_cnt = 0;
  int mw_resp_cyc = -1, mr_resp_cyc = -1, mr_start_cyc = -1;
  int rd_cycles = 0, busy_cycles = 0;
  bit prev_rd = 1'b0;

  function automatic line_t mem_line(input logic [15:0] a);
    return {4{a, ~a}};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_mw(input logic [15:0] a, input line_t d);
    mw_exp_t m;
    m.addr = a;
    m.data = d;
    exp_mw.push_back(m);
  endtask

  // For reads, d is the expected line; for writes, the data written.
  task automatic l2_req(input bit wr, input logic [15:0] a, input line_t d,
                        output int t_req, output int t_resp);
    l2_exp_t e;
    e.is_read = !wr;
    e.data    = wr ? '0 : d;
    exp_l2.push_back(e);
    @(posedge clk); #1;
    t_req    = cyc;
    t_resp   = -1;
    l2_addr  = a;
    l2_wdata = wr ? d : '0;
    l2_write = wr;
    l2_read  = !wr;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (l2_resp) begin
        t_resp = cyc;
        break;
      end
    end
    l2_write = 1'b0;
    l2_read  = 1'b0;
    if (t_resp < 0) begin
      n_checks++;
      $display("FAIL l2_resp_timeout: addr %h got no response within 300 cycles", a);
    end
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (wb_empty) break;
    end
    check("wb_empty_after_drain", wb_empty, 1);
  endtask

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Memory model: responds mem_lat cycles after a request is seen, unless stalled.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if ((pmem_read || pmem_write) && !mem_stall) begin
        if (wait_cnt >= mem_lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = pmem_read ? mem_line(pmem_address) : '0;
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops scoreboard entries whenever the DUT completes something.
  initial begin
    l2_exp_t     e;
    mw_exp_t     m;
    logic [15:0] ra;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (l2_resp) begin
          if (exp_l2.size() == 0) begin
            n_checks++;
            $display("FAIL l2_resp_unexpected: got a response with none outstanding");
          end else begin
            e = exp_l2.pop_front();
            if (e.is_read) check("l2_rdata", l2_rdata, e.data);
          end
        end
        if (pmem_write && pmem_resp) begin
          mw_resp_cyc = cyc;
          if (exp_mw.size() == 0) begin
            n_checks++;
            $display("FAIL pmem_write_unexpected: got write to %h", pmem_address);
          end else begin
            m = exp_mw.pop_front();
            check("pmem_address_w", pmem_address, m.addr);
            check("pmem_wdata", pmem_wdata, m.data);
          end
        end
        if (pmem_read && pmem_resp) begin
          mr_resp_cyc = cyc;
          if (exp_mr.size() == 0) begin
            n_checks++;
            $display("FAIL pmem_read_unexpected: got read of %h", pmem_address);
          end else begin
            ra = exp_mr.pop_front();
            check("pmem_address_r", pmem_address, ra);
          end
        end
        if (pmem_read && !prev_rd) mr_start_cyc = cyc;
        prev_rd = pmem_read;
        if (pmem_read) rd_cycles++;
        if (pmem_read || pmem_write) busy_cycles++;
      end else begin
        prev_rd = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tq, tr, base;
    rst_n    = 1'b0;
    l2_read  = 1'b0;
    l2_write = 1'b0;
    l2_addr  = '0;
    l2_wdata = '0;
    repeat (2) @(posedge clk); #1;

    check("rst_l2_resp", l2_resp, 0);
    check("rst_l2_rdata", l2_rdata, 0);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_pmem_address", pmem_address, 0);
    check("rst_pmem_wdata", pmem_wdata, 0);
    check("rst_wb_empty", wb_empty, 1);
    rst_n = 1'b1;

    // Single write and its background drain.
    push_mw(16'h1230, LINE_A);
    l2_req(1, 16'h1230, LINE_A, tq, tr);
    check("write_resp_lat", tr - tq, 1);
    @(negedge clk);
    check("drain_pmem_write", pmem_write, 1);
    check("drain_pmem_address", pmem_address, 16'h1230);
    check("wb_empty_while_buffered", wb_empty, 0);
    wait_empty();

    // Read hit on an entry whose drain is in flight.
    mem_stall = 1'b1;
    push_mw(16'h0040, LINE_A);
    l2_req(1, 16'h0040, LINE_A, tq, tr);
    base = rd_cycles;
    l2_req(0, 16'h0048, LINE_A, tq, tr);
    check("read_hit_lat", tr - tq, 1);
    check("read_hit_no_pmem_read", rd_cycles - base, 0);
    mem_stall = 1'b0;
    wait_empty();

    // Fill to DEPTH with memory stalled; the fifth write waits for a free slot.
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_mw(16'h1000 + 16'(i * 16), LINE_B ^ line_t'(i));
      l2_req(1, 16'h1000 + 16'(i * 16), LINE_B ^ line_t'(i), tq, tr);
      check("fill_write_lat", tr - tq, 1);
    end
    push_mw(16'h1040, LINE_E);
    fork
      l2_req(1, 16'h1040, LINE_E, tq, tr);
      begin
        repeat (6) @(posedge clk);
        #1 mem_stall = 1'b0;
      end
    join
    check("full_write_resp_after_free", tr - mw_resp_cyc, 2);
    wait_empty();

    // Same-line writes while an older head drains; head itself never coalesces.
    mem_stall = 1'b1;
    push_mw(16'h0200, LINE_C);
    l2_req(1, 16'h0200, LINE_C, tq, tr);
    @(negedge clk);
    check("coal_head_inflight_addr", pmem_address, 16'h0200);
`ifndef L2_WB_COALESCE_EN
    push_mw(16'h0100, LINE_A);
`endif
    push_mw(16'h0100, LINE_B);
    push_mw(16'h0200, LINE_D);
    l2_req(1, 16'h0100, LINE_A, tq, tr);
    l2_req(1, 16'h0100, LINE_B, tq, tr);
    l2_req(1, 16'h0200, LINE_D, tq, tr);
    check("coal_last_write_lat", tr - tq, 1);
    l2_req(0, 16'h0208, LINE_D, tq, tr);
    l2_req(0, 16'h0104, LINE_B, tq, tr);
    mem_stall = 1'b0;
    wait_empty();

    // Read miss behind an in-flight drain.
    mem_stall = 1'b1;
    push_mw(16'h0500, LINE_E);
    l2_req(1, 16'h0500, LINE_E, tq, tr);
    @(negedge clk);
    check("miss_drain_active", pmem_write, 1);
    exp_mr.push_back(16'h3000);
    fork
      l2_req(0, 16'h3000, mem_line(16'h3000), tq, tr);
      begin
        repeat (4) @(negedge clk);
        check("miss_waits_for_drain", pmem_read, 0);
        @(posedge clk);
        #1 mem_stall = 1'b0;
      end
    join
    check("miss_read_after_drain_resp", mr_start_cyc - mw_resp_cyc, 1);
    check("miss_l2_resp_lat", tr - mr_resp_cyc, 1);
    wait_empty();

    // Read miss with the memory side idle.
    exp_mr.push_back(16'h4000);
    l2_req(0, 16'h4000, mem_line(16'h4000), tq, tr);
    check("idle_miss_pmem_read_start", mr_start_cyc - tq, 1);
    check("idle_miss_l2_resp_lat", tr - mr_resp_cyc, 1);

    // Reset in the middle of a drain discards everything.
    mem_stall = 1'b1;
    l2_req(1, 16'h0600, LINE_F, tq, tr);
    @(negedge clk);
    check("rst_drain_active", pmem_write, 1);
    l2_req(1, 16'h0610, LINE_A, tq, tr);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_pmem_write", pmem_write, 0);
    check("midrst_pmem_address", pmem_address, 0);
    check("midrst_pmem_wdata", pmem_wdata, 0);
    check("midrst_wb_empty", wb_empty, 1);
    repeat (2) @(posedge clk); #1;
    rst_n     = 1'b1;
    mem_stall = 1'b0;
    base      = busy_cycles;
    repeat (20) @(posedge clk); #1;
    check("no_traffic_after_reset", busy_cycles - base, 0);
    check("wb_empty_after_reset", wb_empty, 1);

    check("l2_scoreboard_drained", exp_l2.size(), 0);
    check("mw_scoreboard_drained", exp_mw.size(), 0);
    check("mr_scoreboard_drained", exp_mr.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
